// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 keypad scanner with frame-level debounce and HHMM time entry.
// Define KEYPAD_RANGE_CHECK_EN to reject an entry whose hour > 23 or minute > 59.
module keypad_entry #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic        clk,
   input  logic        clr,
   output logic [3:0]  row,
   input  logic [3:0]  col,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic [15:0] entry_bcd,
   output logic [2:0]  entry_cnt,
   output logic [7:0]  set_hour,
   output logic [7:0]  set_minute,
   output logic        set_load,
   output logic        err,
   output logic [1:0]  dbg_state
);
   localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CW = $clog2(DEBOUNCE + 1);
   localparam logic [3:0] KEY_MAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD};

   typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

   logic [DW-1:0] div_q, div_d;
   logic [1:0]    row_idx_q, row_idx_d;
   logic [3:0]    col_s1_q, col_s2_q;
   logic [1:0]    hit_n_q, hit_n_d;
   logic [3:0]    hit_key_q, hit_key_d;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    cand_q, cand_d;
   logic          key_valid_q;
   logic [3:0]    key_code_q;
   logic [15:0]   entry_bcd_q, entry_bcd_d;
   logic [2:0]    entry_cnt_q, entry_cnt_d;
   logic [7:0]    set_hour_q, set_hour_d, set_minute_q, set_minute_d;
   logic          set_load_q, set_load_d, err_q, err_d;

   logic          slot_end, frame_end, fr_hit, fr_none, reach, accept, entry_ok;
   logic [3:0]    hits, fr_key;
   logic [2:0]    slot_n, tot;
   logic [1:0]    col_idx;
   logic [31:0]   cnt_inc;
   logic [7:0]    hour_bin, min_bin;

   // Scan timing: one row per SCAN_DIV cycles, frame ends on the last cycle of row 3.
   assign slot_end  = (div_q == DW'(SCAN_DIV - 1));
   assign frame_end = slot_end && (row_idx_q == 2'd3);
   assign row       = ~(4'b0001 << row_idx_q);
   assign hits      = ~col_s2_q;

   always_comb begin
      div_d     = slot_end ? '0 : div_q + DW'(1);
      row_idx_d = slot_end ? row_idx_q + 2'd1 : row_idx_q;
      slot_n    = 3'(hits[0]) + 3'(hits[1]) + 3'(hits[2]) + 3'(hits[3]);
      col_idx   = 2'd0;
      for (int c = 0; c < 4; c++) begin
         if (hits[c]) col_idx = 2'(c);
      end
      tot       = {1'b0, hit_n_q} + slot_n;
      fr_key    = (slot_n == 3'd1) ? KEY_MAP[{row_idx_q, col_idx}] : hit_key_q;
      fr_hit    = frame_end && (tot == 3'd1);
      fr_none   = frame_end && (tot != 3'd1);
      hit_n_d   = hit_n_q;
      hit_key_d = hit_key_q;
      if (frame_end) begin
         hit_n_d   = 2'd0;
         hit_key_d = 4'd0;
      end else if (slot_end) begin
         hit_n_d   = (tot >= 3'd2) ? 2'd2 : tot[1:0];
         hit_key_d = fr_key;
      end
   end

   assign cnt_inc = 32'(cnt_q) + 32'd1;
   assign reach   = (cnt_inc >= DEBOUNCE);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      case (state_q)
         IDLE: if (fr_hit) begin
            cand_d  = fr_key;
            cnt_d   = CW'(1);
            state_d = (DEBOUNCE <= 1) ? HELD : PRESS_CHK;
         end
         PRESS_CHK: if (fr_hit && fr_key == cand_q) begin
            if (reach) state_d = HELD;
            else       cnt_d   = CW'(cnt_inc);
         end else if (frame_end) begin
            state_d = IDLE;
         end
         HELD: if (fr_none) begin
            cnt_d   = CW'(1);
            state_d = (DEBOUNCE <= 1) ? IDLE : REL_CHK;
         end
         REL_CHK: if (fr_hit) begin
            state_d = HELD;
         end else if (fr_none) begin
            if (reach) state_d = IDLE;
            else       cnt_d   = CW'(cnt_inc);
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      accept    = fr_hit && (((state_q == IDLE) && (DEBOUNCE <= 1)) ||
                             ((state_q == PRESS_CHK) && (fr_key == cand_q) && reach));
      dbg_state = state_q;
   end

   // Time entry acts one cycle after the key_valid pulse, digits read HHMM.
   assign hour_bin = 8'(entry_bcd_q[15:12]) * 8'd10 + 8'(entry_bcd_q[11:8]);
   assign min_bin  = 8'(entry_bcd_q[7:4]) * 8'd10 + 8'(entry_bcd_q[3:0]);
`ifdef KEYPAD_RANGE_CHECK_EN
   assign entry_ok = (hour_bin <= 8'd23) && (min_bin <= 8'd59);
`else
   assign entry_ok = 1'b1;
`endif

   always_comb begin
      entry_bcd_d  = entry_bcd_q;
      entry_cnt_d  = entry_cnt_q;
      set_hour_d   = set_hour_q;
      set_minute_d = set_minute_q;
      set_load_d   = 1'b0;
      err_d        = 1'b0;
      if (key_valid_q) begin
         if (key_code_q <= 4'd9) begin
            if (entry_cnt_q != 3'd4) begin
               entry_bcd_d = {entry_bcd_q[11:0], key_code_q};
               entry_cnt_d = entry_cnt_q + 3'd1;
            end
         end else if (key_code_q == 4'hE || key_code_q == 4'hF) begin
            entry_bcd_d = 16'd0;
            entry_cnt_d = 3'd0;
            if (key_code_q == 4'hF) begin
               if (entry_cnt_q == 3'd4 && entry_ok) begin
                  set_hour_d   = hour_bin;
                  set_minute_d = min_bin;
                  set_load_d   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         div_q        <= '0;
         row_idx_q    <= 2'd0;
         col_s1_q     <= 4'd0;
         col_s2_q     <= 4'd0;
         hit_n_q      <= 2'd0;
         hit_key_q    <= 4'd0;
         cnt_q        <= '0;
         cand_q       <= 4'd0;
         key_valid_q  <= 1'b0;
         key_code_q   <= 4'd0;
         entry_bcd_q  <= 16'd0;
         entry_cnt_q  <= 3'd0;
         set_hour_q   <= 8'd0;
         set_minute_q <= 8'd0;
         set_load_q   <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         div_q        <= div_d;
         row_idx_q    <= row_idx_d;
         col_s1_q     <= col;
         col_s2_q     <= col_s1_q;
         hit_n_q      <= hit_n_d;
         hit_key_q    <= hit_key_d;
         cnt_q        <= cnt_d;
         cand_q       <= cand_d;
         key_valid_q  <= accept;
         if (accept) key_code_q <= fr_key;
         entry_bcd_q  <= entry_bcd_d;
         entry_cnt_q  <= entry_cnt_d;
         set_hour_q   <= set_hour_d;
         set_minute_q <= set_minute_d;
         set_load_q   <= set_load_d;
         err_q        <= err_d;
      end
   end

   assign key_code   = key_code_q;
   assign key_valid  = key_valid_q;
   assign entry_bcd  = entry_bcd_q;
   assign entry_cnt  = entry_cnt_q;
   assign set_hour   = set_hour_q;
   assign set_minute = set_minute_q;
   assign set_load   = set_load_q;
   assign err        = err_q;
endmodule
